// File: rtl/mem_arbiter_2p_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin arbitration is selected with MEM_ARB_RR_EN (see rr_arbiter_2).
package mem_arb_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned CS_W    = 4;
  // Holds read latencies 1..15.
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_2p_if.sv
// Requester and memory-system signals of the two-port arbiter, bundled as one interface.
// slave: arbiter side; master: requesters plus memory system.
interface mem_arbiter_2p_if;
  import mem_arb_pkg::*;

  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_din;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_din;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic [CS_W-1:0]   mem_cs;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_din,
    input  req1_valid, req1_we, req1_addr, req1_din,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output mem_we, mem_addr, mem_din,
    input  mem_dout, mem_cs
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_din,
    output req1_valid, req1_we, req1_addr, req1_din,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  mem_we, mem_addr, mem_din,
    output mem_dout, mem_cs
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way grant logic. MEM_ARB_RR_EN defined: round-robin on the last granted port;
// undefined: fixed priority with port 0 winning every tie.
module rr_arbiter_2
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    grant_o = '0;
    if (en_i) begin
      if (&valid_i) begin
        grant_o = last_q ? 2'b01 : 2'b10;
      end else begin
        grant_o = valid_i;
      end
    end
  end

  // A grant is always accepted, so the pointer follows the grant itself.
  always_comb begin
    last_d = last_q;
    if (|grant_o) begin
      last_d = grant_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    grant_o = '0;
    if (en_i) begin
      grant_o[0] = valid_i[0];
      grant_o[1] = valid_i[1] & ~valid_i[0];
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter_2p.sv
// Serialises two valid/ready requesters onto the four-bank memory system, one access at a time.
// Arbitration mode follows MEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_2p_if.slave bus
);

  arb_state_t         state_q, state_d;
  logic               owner_q, owner_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] grant;
  logic               arb_en;
  logic               accept;
  logic               cs_miss;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_din;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign arb_en    = (state_q == StIdle);

  rr_arbiter_2 u_rr (
`ifdef MEM_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .en_i    (arb_en),
    .valid_i (req_valid),
    .grant_o (grant)
  );

  assign accept   = |grant;
  assign sel_we   = grant[1] ? bus.req1_we   : bus.req0_we;
  assign sel_addr = grant[1] ? bus.req1_addr : bus.req0_addr;
  assign sel_din  = grant[1] ? bus.req1_din  : bus.req0_din;
  assign cs_miss  = (bus.mem_cs == '0);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = '0;
    rsp_err_d   = '0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d    = grant[1];
          mem_we_d   = sel_we;
          mem_addr_d = sel_addr;
          mem_din_d  = sel_din;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        err_d = cs_miss;
        if (mem_we_q) begin
          // Write completes here; its response carries zero data.
          rsp_data_d           = '0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d[owner_q]   = cs_miss;
          state_d              = StResp;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d           = bus.mem_dout;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d[owner_q]   = err_q;
          state_d              = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp0_err   = rsp_err_q[0];
  assign bus.rsp1_err   = rsp_err_q[1];
  assign bus.rsp0_data  = rsp_data_q;
  assign bus.rsp1_data  = rsp_data_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;

endmodule

// File: doc/mem_arbiter_2p.md
# mem_arbiter_2p

Two-port arbiter that shares the four-bank 16-bit-address, 8-bit-data memory system between two independent requesters (e.g. CPU port and DMA port). Each requester uses a valid/ready request handshake and gets a one-cycle response pulse. The arbiter serialises accesses, drives the memory system's `we`/`addr`/`din`, waits a fixed read latency and returns `dout` with the owning requester's response. It sits directly in front of the memory system, which is otherwise unchanged.

## Interface
- `RD_LAT`, default 2: cycles from the ISSUE cycle until `mem_dout` is valid. Legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: the requester presents a transaction.
- `req0_we`, `req1_we` in 1: 1 = write, 0 = read.
- `req0_addr`, `req1_addr` in 16: byte address.
- `req0_din`, `req1_din` in 8: write data.
- `req0_ready`, `req1_ready` out 1: the request is accepted when valid and ready are both high.
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle completion pulse.
- `rsp0_data`, `rsp1_data` out 8: read data. The value is 0 for writes.
- `rsp0_err`, `rsp1_err` out 1: the address hit no bank. Qualified by `rspN_valid`.
- `mem_we` out 1, `mem_addr` out 16, `mem_din` out 8: drive the memory system.
- `mem_dout` in 8, `mem_cs` in 4: memory system outputs.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - At most one `reqN_ready` is high, going to the arbitration winner; `reqN_ready` is combinational from the valids and the priority pointer.
  - Both ready lines are low when no request is valid.
  - On acceptance, latch owner, we, addr and din, then go to ISSUE.
- **ISSUE**
  - `mem_addr` and `mem_din` show the latched values.
  - `mem_we` equals the latched we. `mem_we` is 0 in every other state.
  - Sample `mem_cs`: 4'b0000 sets the error flag.
  - Writes go to RESP. Reads load the counter with `RD_LAT` and go to WAIT.
- **WAIT**
  - `mem_addr` is held. The counter decrements each cycle.
  - When the counter reaches 1, capture `mem_dout` into the response register and go to RESP.
- **RESP**
  - The owner's `rspN_valid` is 1 for exactly one cycle, with data and err. Then go to IDLE.
- Both ready lines are low in ISSUE, WAIT and RESP. There is no pipelining: one transaction is outstanding at a time.
- Arbitration: a round-robin pointer `last` records the last granted port.
  - When both ports are valid, the port ≠ `last` wins.
  - `last` updates only on acceptance. Reset value of `last` is 1, so port 0 wins the first tie.
- A non-owner's `rsp` is never asserted.
- Unaccepted requests must hold their fields stable. The arbiter does not check this.

## Timing
- Cycle numbers are counted from acceptance cycle 0:
  - Read: ISSUE in cycle 1, `mem_dout` valid in cycle 1+RD_LAT, `rsp` in cycle 2+RD_LAT, IDLE in 3+RD_LAT.
  - Write: ISSUE in cycle 1 (RAM write on the edge ending cycle 1), `rsp` in cycle 2, IDLE in cycle 3.
- Back-to-back throughput is one read per RD_LAT+3 cycles and one write per 3 cycles.
- Reset values:
  - All `ready`, `rsp_valid` and `rsp_err` = 0; `rsp_data` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0.
  - `last` = 1.
- Reset mid-operation:
  - The FSM goes to IDLE at the next edge and the in-flight transaction is dropped with no response.
  - A write whose ISSUE cycle coincides with `rst` high still commits, because the RAM samples the same edge.
- A simultaneous valid on both ports in the cycle after RESP is arbitrated normally by `last`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration as above.
- Not defined: fixed priority, where port 0 always wins a tie and `last` is not implemented. Port 1 can starve under continuous port 0 traffic, and this is accepted behaviour.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_t` (IDLE, ISSUE, WAIT, RESP).
  - Constants `ADDR_W`=16, `DATA_W`=8, `NUM_REQ`=2, `CS_W`=4.
- Sub-module `rr_arbiter_2`: combinational grant from the two valids and `last`, plus the registered `last` update on accept. Its body is compiled according to `MEM_ARB_RR_EN`.

## Test plan
- Reset, then port 0 writes 0xA5 to 0x0010, then reads 0x0010 → `rsp0_valid` in cycle 2 with data 0; read `rsp0_data`=0xA5 in cycle 4 (RD_LAT=2).
- Both ports valid in the same cycle, reading different addresses, repeated 4 times → grants alternate 0,1,0,1 with `MEM_ARB_RR_EN`; without the macro → 0,0,0,0 and port 1 is never served while port 0 stays valid.
- Port 1 reads an address whose `mem_cs`=0000 → `rsp1_valid`=1, `rsp1_err`=1, `rsp0_valid` stays 0.
- Assert `rst` during WAIT of a port 0 read → no `rsp0_valid`, outputs at reset values, next request accepted normally with port 0 winning a tie.
- Port 1 writes 0x3C to 0x0400 (bank 1) while port 0 keeps valid high → `req0_ready` stays low until IDLE; then port 0's read of 0x0400 returns 0x3C.
- RD_LAT=4 read → `rsp` in cycle 6, with `mem_addr` held from cycle 1 through cycle 5.
